ccip_avmm_mmio_master: RTL

Avalon-MM master that executes decoded MMIO commands (`t_ccip_avmm_mmio_cmd` from `ccip_avmm_pkg`) against the AFU's Avalon register space and returns read data tagged with the originating CCI-P transaction ID. It is the response side of the MMIO path. Upstream, the CCI-P C0 MMIO decoder feeds it commands. Its response outputs drive the C2 MMIO read-response formatter.

---
 rtl/ccip_avmm_mmio_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ccip_avmm_mmio_master.sv
// MMIO command -> Avalon-MM master with in-order read tag tracking; optional counters via CCIP_AVMM_MMIO_STATS_EN.
// Latency: request asserted 1 cycle after accept, response 1 cycle after readdatavalid.
// Backpressure: cmd_ready low while a request is in flight or (reads only) the tag FIFO is full.
package ccip_avmm_pkg;
  typedef struct packed {
    logic        is_read;
    logic        is_32bit;
    logic [17:0] addr;
    logic [63:0] write_data;
  } t_ccip_avmm_mmio_cmd;
endpackage

module ccip_avmm_mmio_master
  import ccip_avmm_pkg::*;
#(
  parameter int TID_WIDTH       = 9,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [$bits(t_ccip_avmm_mmio_cmd)-1:0] cmd,
  input  logic [TID_WIDTH-1:0]                  cmd_tid,
  output logic [17:0]                           avm_address,
  output logic                                  avm_read,
  output logic                                  avm_write,
  output logic [63:0]                           avm_writedata,
  output logic [7:0]                            avm_byteenable,
  input  logic                                  avm_waitrequest,
  input  logic [63:0]                           avm_readdata,
  input  logic                                  avm_readdatavalid,
  output logic                                  rsp_valid,
  output logic [TID_WIDTH-1:0]                  rsp_tid,
  output logic [63:0]                           rsp_data,
  output logic                                  err_unexpected_rsp
`ifdef CCIP_AVMM_MMIO_STATS_EN
  ,
  output logic [31:0]                           stat_reads,
  output logic [31:0]                           stat_writes,
  output logic [31:0]                           stat_wait_cycles
`endif
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = TID_WIDTH + 2;

  typedef enum logic {IDLE, ISSUE} state_t;

  t_ccip_avmm_mmio_cmd c;
  state_t              state, state_nxt;

  logic [TAG_W-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] tag_cnt;
  logic             tag_full, tag_empty;
  logic             accept, push, pop;

  logic [TID_WIDTH-1:0] head_tid;
  logic                 head_32bit, head_hi;

  assign c         = cmd;
  assign tag_full  = (tag_cnt == CNT_W'(MAX_OUTSTANDING));
  assign tag_empty = (tag_cnt == '0);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && c.is_read;
  assign pop       = avm_readdatavalid && !tag_empty;
  assign {head_tid, head_32bit, head_hi} = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !reset && (!c.is_read || !tag_full);
        if (cmd_valid && cmd_ready) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!avm_waitrequest) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at accept and stay frozen for the whole stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
    end else if (accept) begin
      avm_address    <= c.addr & ~18'h7;
      avm_read       <= c.is_read;
      avm_write      <= !c.is_read;
      if (!c.is_32bit)      avm_byteenable <= 8'hFF;
      else if (c.addr[2])   avm_byteenable <= 8'hF0;
      else                  avm_byteenable <= 8'h0F;
      avm_writedata  <= c.is_32bit ? {2{c.write_data[31:0]}} : c.write_data;
    end else if (state == ISSUE && !avm_waitrequest) begin
      avm_read  <= 1'b0;
      avm_write <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= {cmd_tid, c.is_32bit, c.addr[2]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid          <= 1'b0;
      rsp_tid            <= '0;
      rsp_data           <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      rsp_valid <= pop;
      if (pop) begin
        rsp_tid <= head_tid;
        if (!head_32bit)  rsp_data <= avm_readdata;
        else if (head_hi) rsp_data <= {32'h0, avm_readdata[63:32]};
        else              rsp_data <= {32'h0, avm_readdata[31:0]};
      end
      if (avm_readdatavalid && tag_empty) err_unexpected_rsp <= 1'b1;
    end
  end

`ifdef CCIP_AVMM_MMIO_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads       <= '0;
      stat_writes      <= '0;
      stat_wait_cycles <= '0;
    end else if (state == ISSUE) begin
      if (avm_waitrequest) stat_wait_cycles <= stat_wait_cycles + 32'd1;
      else if (avm_read)   stat_reads       <= stat_reads + 32'd1;
      else if (avm_write)  stat_writes      <= stat_writes + 32'd1;
    end
  end
`endif

endmodule
